// File: rtl/notas_prog_pkg.sv
// notas_prog_pkg: shared widths, 12 MHz note divisors and address-width helper
package notas_prog_pkg;
    localparam int DW_DEF = 16;
    typedef enum logic [DW_DEF-1:0] {
        DO  = 16'd45872,
        RE  = 16'd40858,
        MI  = 16'd36408,
        FA  = 16'd34364,
        SOL = 16'd30612,
        LA  = 16'd27273,
        SI  = 16'd24296,
        DO2 = 16'd22936
    } note_t;
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/notas_prog_tone_div.sv
// tone_div: one programmable square-wave channel (divisor, counter, registered output)
module tone_div
    import notas_prog_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DIV_RST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [DW-1:0] ld_val,
    input  logic          en,
    output logic          out,
    output logic          nxt
);
    logic [DW-1:0] div;
    logic [DW-1:0] cnt;
    logic          mute;
    always_comb begin
        mute = !en || (div < DW'(2));
        nxt  = (ld || mute) ? 1'b0 : (cnt >= (div >> 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= DW'(DIV_RST);
            cnt <= '0;
            out <= 1'b0;
        end else begin
            if (ld)
                div <= ld_val;
            cnt <= (ld || mute || cnt == div - DW'(1)) ? '0 : cnt + DW'(1);
            out <= nxt;
        end
    end
endmodule

// File: rtl/notas_prog.sv
// notas_prog: NCH programmable note channels with write-port decode and a selectable mix output
module notas_prog
    import notas_prog_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int DW      = DW_DEF,
    parameter int DIV_RST = 4,
    parameter int AW      = addr_w(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic [NCH-1:0] en,
    input  logic [AW-1:0]  sel,
    output logic [NCH-1:0] ch,
    output logic           mix
);
    logic [NCH-1:0] nxt;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tone_div #(.DW(DW), .DIV_RST(DIV_RST)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .ld     (wr_en && wr_addr == AW'(i)),
            .ld_val (wr_data),
            .en     (en[i]),
            .out    (ch[i]),
            .nxt    (nxt[i])
        );
    end
    // mix takes the channel's next value so it lines up with ch[sel] in the same cycle
    always_ff @(posedge clk) begin
        if (rst)
            mix <= 1'b0;
        else
            mix <= (int'(sel) < NCH) ? nxt[sel] : 1'b0;
    end
endmodule
